// File: rtl/wr_burst_ctrl.sv
// wr_burst_ctrl: write-path scheduler from the DDR2 write FIFO to the MIG.
// Issues one write command per WRITE_BURST words, then moves that burst into
// the write-data FIFO. MIG back-pressure is honoured. The command address
// walks a ring that runs from base_addr to last_addr (inclusive).
// Optional feature: define WR_BURST_CTRL_STATS_EN to count completed bursts
// on burst_count; otherwise burst_count is tied to zero.
module wr_burst_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int WRITE_BURST = 8,
  parameter int ADDR_WIDTH  = 31,
  parameter int ADDR_INC    = 4
) (
  input  logic                  rd_clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  phy_init_done,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] last_addr,
  input  logic                  prog_empty,
  input  logic                  dout_vd,
  input  logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_fifo,
  input  logic                  app_af_afull,
  input  logic                  app_wdf_afull,
  output logic                  app_af_wren,
  output logic [2:0]            app_af_cmd,
  output logic [ADDR_WIDTH-1:0] app_af_addr,
  output logic                  app_wdf_wren,
  output logic [DATA_WIDTH-1:0] app_wdf_data,
  output logic                  busy,
  output logic [31:0]           burst_count
);

  localparam int CNT_W = $clog2(WRITE_BURST) + 1;
  localparam logic [CNT_W-1:0]      BURST_LEN  = CNT_W'(WRITE_BURST);
  localparam logic [CNT_W-1:0]      BURST_LAST = CNT_W'(WRITE_BURST - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(ADDR_INC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        rd_issued_r;
  logic [CNT_W-1:0]        wd_sent_r;
  logic [ADDR_WIDTH-1:0]   cur_addr_r;
  logic [ADDR_WIDTH-1:0]   base_r;
  logic                    af_wren_r;
  logic                    wdf_wren_r;
  logic [DATA_WIDTH-1:0]   wdf_data_r;
  logic                    busy_r;
  logic                    start_s;
  logic                    rd_en_s;
  logic                    last_word_s;
  logic                    accept_s;

  // Next-state decode plus the combinational FIFO pop, which must react to
  // app_wdf_afull in the same cycle.
  always_comb begin
    state_s     = state_r;
    rd_en_s     = 1'b0;
    start_s     = enable & phy_init_done & ~prog_empty & ~app_af_afull & ~app_wdf_afull;
    last_word_s = wdf_wren_r & (wd_sent_r == BURST_LAST);
    case (state_r)
      IDLE: begin
        if (start_s) state_s = CMD;
        else         state_s = IDLE;
      end
      CMD: begin
        state_s = DATA;
      end
      DATA: begin
        if ((rd_issued_r < BURST_LEN) && !app_wdf_afull) rd_en_s = 1'b1;
        else                                             rd_en_s = 1'b0;
        if (last_word_s) state_s = DONE;
        else             state_s = DATA;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Words returned by the FIFO are only forwarded while a burst is moving data.
  assign accept_s = dout_vd & (state_r == DATA);

  // State register and registered MIG strobes.
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      state_r    <= IDLE;
      af_wren_r  <= 1'b0;
      busy_r     <= 1'b0;
      wdf_wren_r <= 1'b0;
      wdf_data_r <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      af_wren_r  <= (state_s == CMD);
      busy_r     <= (state_s != IDLE);
      wdf_wren_r <= accept_s;
      if (accept_s) wdf_data_r <= data_out;
      else          wdf_data_r <= wdf_data_r;
    end
  end

  // Per-burst pop and forward counters, cleared when the command goes out.
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      rd_issued_r <= {CNT_W{1'b0}};
      wd_sent_r   <= {CNT_W{1'b0}};
    end else if (state_r == CMD) begin
      rd_issued_r <= {CNT_W{1'b0}};
      wd_sent_r   <= {CNT_W{1'b0}};
    end else if (state_r == DATA) begin
      if (rd_en_s)    rd_issued_r <= rd_issued_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else            rd_issued_r <= rd_issued_r;
      if (wdf_wren_r) wd_sent_r   <= wd_sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
      else            wd_sent_r   <= wd_sent_r;
    end else begin
      rd_issued_r <= rd_issued_r;
      wd_sent_r   <= wd_sent_r;
    end
  end

  // Ring address: base is tracked while idle, and the address steps once per burst.
  always_ff @(posedge rd_clk) begin
    if (!reset) begin
      cur_addr_r <= base_addr;
      base_r     <= base_addr;
    end else begin
      if (!busy_r) base_r <= base_addr;
      else         base_r <= base_r;
      if (state_r == DONE) begin
        if (cur_addr_r == last_addr) cur_addr_r <= base_r;
        else                         cur_addr_r <= cur_addr_r + ADDR_STEP;
      end else begin
        cur_addr_r <= cur_addr_r;
      end
    end
  end

`ifdef WR_BURST_CTRL_STATS_EN
  logic [31:0] burst_count_r;

  // Completed-burst counter; it wraps naturally at 2^32.
  always_ff @(posedge rd_clk) begin
    if (!reset)                burst_count_r <= 32'd0;
    else if (state_r == DONE)  burst_count_r <= burst_count_r + 32'd1;
    else                       burst_count_r <= burst_count_r;
  end

  assign burst_count = burst_count_r;
`else
  assign burst_count = 32'd0;
`endif

  assign rd_fifo      = rd_en_s;
  assign app_af_wren  = af_wren_r;
  assign app_af_cmd   = 3'b000;
  assign app_af_addr  = cur_addr_r;
  assign app_wdf_wren = wdf_wren_r;
  assign app_wdf_data = wdf_data_r;
  assign busy         = busy_r;

endmodule

// File: tb/tb_wr_burst_ctrl.sv
// tb_wr_burst_ctrl: directed bench for wr_burst_ctrl. A FIFO model feeds the
// DUT. A transaction-level model predicts the command addresses, the pop and
// forward behaviour, busy and burst_count on every cycle.
`timescale 1ns/1ps
module tb_wr_burst_ctrl;
  localparam int DW   = 64;
  localparam int WB   = 8;
  localparam int AW   = 31;
  localparam int AINC = 4;
`ifdef WR_BURST_CTRL_STATS_EN
  localparam int STATS_ON = 1;
`else
  localparam int STATS_ON = 0;
`endif

  logic          rd_clk        = 1'b0;
  logic          reset         = 1'b0;
  logic          enable        = 1'b1;
  logic          phy_init_done = 1'b1;
  logic [AW-1:0] base_addr     = '0;
  logic [AW-1:0] last_addr     = '0;
  logic          prog_empty;
  logic          dout_vd       = 1'b0;
  logic [DW-1:0] data_out      = '0;
  logic          app_af_afull  = 1'b0;
  logic          app_wdf_afull = 1'b0;
  logic          rd_fifo;
  logic          app_af_wren;
  logic [2:0]    app_af_cmd;
  logic [AW-1:0] app_af_addr;
  logic          app_wdf_wren;
  logic [DW-1:0] app_wdf_data;
  logic          busy;
  logic [31:0]   burst_count;

  // FIFO model storage and bench bookkeeping.
  logic [DW-1:0] mem [0:127];
  int            wr_ptr     = 0;
  int            rd_ptr     = 0;
  logic          pe_force   = 1'b0;
  int            cyc        = 0;
  logic          rst_q      = 1'b0;
  logic          start_q    = 1'b0;
  logic          dv_q       = 1'b0;
  int            tot_wren   = 0;
  int            tot_cmd    = 0;
  logic [DW-1:0] last_wdata = '0;
  int            n_checks   = 0;
  int            n_fail     = 0;

  // Transaction-level model state.
  bit            in_burst;
  bit            in_data;
  bit            done_now;
  bit            done_next;
  bit            data_prev;
  int            cmd_cyc;
  int            rd_cnt;
  int            wr_cnt;
  int            last_done_cyc = -10;
  logic [AW-1:0] exp_addr;
  logic [31:0]   exp_bc;
  logic [DW-1:0] exp_q [$];

  assign prog_empty = pe_force || ((wr_ptr - rd_ptr) < WB);

  wr_burst_ctrl #(.DATA_WIDTH(DW), .WRITE_BURST(WB), .ADDR_WIDTH(AW), .ADDR_INC(AINC)) dut (
    .rd_clk(rd_clk), .reset(reset), .enable(enable), .phy_init_done(phy_init_done),
    .base_addr(base_addr), .last_addr(last_addr), .prog_empty(prog_empty),
    .dout_vd(dout_vd), .data_out(data_out), .rd_fifo(rd_fifo),
    .app_af_afull(app_af_afull), .app_wdf_afull(app_wdf_afull),
    .app_af_wren(app_af_wren), .app_af_cmd(app_af_cmd), .app_af_addr(app_af_addr),
    .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
    .busy(busy), .burst_count(burst_count)
  );

  // 100 MHz clock.
  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model with one-cycle read latency, plus edge-sampled bookkeeping.
  always @(posedge rd_clk) begin
    cyc     <= cyc + 1;
    rst_q   <= reset;
    start_q <= enable & phy_init_done & ~prog_empty & ~app_af_afull & ~app_wdf_afull;
    dv_q    <= dout_vd;
    if (rd_fifo && (rd_ptr < wr_ptr)) begin
      dout_vd  <= 1'b1;
      data_out <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
    end else begin
      dout_vd  <= 1'b0;
    end
    if (app_wdf_wren) begin
      tot_wren   <= tot_wren + 1;
      last_wdata <= app_wdf_data;
    end
    if (app_af_wren) tot_cmd <= tot_cmd + 1;
  end

  // Every-cycle comparison of DUT outputs against the transaction model.
  always @(negedge rd_clk) begin
    if (cyc > 0) begin
      if (!rst_q) begin
        chk("rst_rd_fifo", 64'(rd_fifo), 64'd0);
        chk("rst_af_wren", 64'(app_af_wren), 64'd0);
        chk("rst_wdf_wren", 64'(app_wdf_wren), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_af_addr", 64'(app_af_addr), 64'(base_addr));
        chk("rst_wdf_data", app_wdf_data, 64'd0);
        chk("rst_burst_count", 64'(burst_count), 64'd0);
        in_burst = 1'b0; done_next = 1'b0; data_prev = 1'b0;
        rd_cnt = 0; wr_cnt = 0; cmd_cyc = 0; last_done_cyc = -10;
        exp_q.delete();
        exp_bc = 32'd0;
        exp_addr = base_addr;
      end else begin
        done_now  = done_next;
        done_next = 1'b0;
        chk("af_cmd", 64'(app_af_cmd), 64'd0);
        chk("burst_count", 64'(burst_count), 64'(exp_bc));
        if (app_af_wren) begin
          chk("cmd_start_cond", 64'(start_q), 64'd1);
          chk("cmd_from_idle", 64'(!in_burst && !done_now && (cyc > last_done_cyc + 1)), 64'd1);
          chk("cmd_addr", 64'(app_af_addr), 64'(exp_addr));
          if (exp_addr == last_addr) exp_addr = base_addr;
          else                       exp_addr = AW'(exp_addr + AW'(AINC));
          in_burst = 1'b1; cmd_cyc = cyc; rd_cnt = 0; wr_cnt = 0;
        end
        in_data = in_burst && (cyc > cmd_cyc);
        chk("busy", 64'(busy), 64'(in_burst || done_now));
        chk("rd_fifo", 64'(rd_fifo), 64'(in_data && (rd_cnt < WB) && !app_wdf_afull));
        chk("wdf_wren", 64'(app_wdf_wren), 64'(dv_q && data_prev));
        if (rd_fifo) begin
          exp_q.push_back(mem[rd_ptr]);
          rd_cnt = rd_cnt + 1;
        end
        if (app_wdf_wren) begin
          chk("wdf_has_pending", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            chk("wdf_data", app_wdf_data, exp_q[0]);
            void'(exp_q.pop_front());
          end
          wr_cnt = wr_cnt + 1;
          if (wr_cnt == WB) begin
            in_burst  = 1'b0;
            done_next = 1'b1;
          end
        end
        if (done_now) begin
          chk("done_no_pending", 64'(exp_q.size()), 64'd0);
          chk("done_reads", 64'(rd_cnt), 64'(WB));
          last_done_cyc = cyc;
          if (STATS_ON != 0) exp_bc = exp_bc + 32'd1;
        end
        data_prev = in_data;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rd_clk);
      #1;
    end
  endtask

  task automatic push_words(input logic [DW-1:0] first, input logic [DW-1:0] step, input int n);
    logic [DW-1:0] v;
    v = first;
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = v;
      wr_ptr = wr_ptr + 1;
      v = v + step;
    end
  endtask

  task automatic wait_cmd(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (app_af_wren) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_cmd", 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick(1);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_idle", 64'(ok), 64'd1);
  endtask

  logic [AW-1:0] ring_exp [4];
  int c0, w0, r0, n0, rel_cyc;

  // Directed stimulus with hand-computed expectations.
  initial begin
    ring_exp[0] = 31'h0; ring_exp[1] = 31'h4; ring_exp[2] = 31'h8; ring_exp[3] = 31'h0;

    // Reset held with a full burst available and enable high.
    base_addr = 31'h100;
    last_addr = 31'h10C;
    push_words(64'h11, 64'h11, 8);
    tick(5);
    chk("rst_hold_no_pop", 64'(rd_ptr), 64'd0);
    chk("rst_hold_addr", 64'(app_af_addr), 64'h100);
    chk("rst_hold_busy", 64'(busy), 64'd0);
    rel_cyc = cyc - 1;
    reset = 1'b1;

    // First burst: CMD two cycles after the last reset-low cycle, done 12 later.
    wait_cmd(10);
    chk("cmd_latency", 64'(cyc - rel_cyc), 64'd2);
    chk("cmd1_addr", 64'(app_af_addr), 64'h100);
    c0 = cyc; w0 = tot_wren;
    wait_idle(40);
    chk("busy_low_cycle", 64'(cyc - c0), 64'd12);
    chk("next_addr", 64'(app_af_addr), 64'h104);
    chk("burst1_words", 64'(tot_wren - w0), 64'd8);
    chk("burst1_last", last_wdata, 64'h88);

    // Back-pressure during burst cycles 4..7.
    push_words(64'hA1, 64'h1, 8);
    wait_cmd(10);
    c0 = cyc; w0 = tot_wren; r0 = rd_ptr;
    tick(3);
    chk("bp_pops_before", 64'(rd_ptr - r0), 64'd2);
    r0 = rd_ptr;
    app_wdf_afull = 1'b1;
    tick(4);
    app_wdf_afull = 1'b0;
    chk("bp_pops_during", 64'(rd_ptr - r0), 64'd0);
    wait_idle(60);
    chk("bp_busy_low_cycle", 64'(cyc - c0), 64'd16);
    chk("bp_words", 64'(tot_wren - w0), 64'd8);
    chk("bp_last", last_wdata, 64'hA8);

    // Ring wrap: base 0, last 8, four bursts.
    reset = 1'b0;
    base_addr = 31'h0;
    last_addr = 31'h8;
    push_words(64'h1000, 64'h1, 32);
    tick(2);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cmd(20);
      chk("ring_addr", 64'(app_af_addr), 64'(ring_exp[k]));
      wait_idle(40);
      if (k == 2) chk("stats_after_3", 64'(burst_count), (STATS_ON != 0) ? 64'd3 : 64'd0);
    end

    // Start gating: each blocking input alone must hold off the command.
    pe_force = 1'b1;
    push_words(64'h2000, 64'h1, 8);
    n0 = tot_cmd; tick(10);
    chk("gate_prog_empty", 64'(tot_cmd - n0), 64'd0);
    pe_force = 1'b0; app_af_afull = 1'b1;
    n0 = tot_cmd; tick(10);
    chk("gate_af_afull", 64'(tot_cmd - n0), 64'd0);
    app_af_afull = 1'b0; phy_init_done = 1'b0;
    n0 = tot_cmd; tick(10);
    chk("gate_phy", 64'(tot_cmd - n0), 64'd0);
    phy_init_done = 1'b1; app_wdf_afull = 1'b1;
    n0 = tot_cmd; tick(10);
    chk("gate_wdf_afull", 64'(tot_cmd - n0), 64'd0);
    app_wdf_afull = 1'b0;

    // enable dropped mid-burst: burst completes, nothing new starts.
    wait_cmd(5);
    chk("gate_release_addr", 64'(app_af_addr), 64'h4);
    w0 = tot_wren;
    tick(3);
    enable = 1'b0;
    wait_idle(40);
    chk("drop_en_words", 64'(tot_wren - w0), 64'd8);
    chk("drop_en_last", last_wdata, 64'h2007);
    push_words(64'h3000, 64'h1, 8);
    n0 = tot_cmd; tick(20);
    chk("drop_en_no_cmd", 64'(tot_cmd - n0), 64'd0);

    // Reset mid-burst: partial burst abandoned, FIFO keeps its remaining words.
    enable = 1'b1;
    wait_cmd(5);
    tick(4);
    reset = 1'b0;
    tick(1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_af_wren", 64'(app_af_wren), 64'd0);
    chk("mid_rst_count", 64'(burst_count), 64'd0);
    chk("mid_rst_addr", 64'(app_af_addr), 64'h0);
    chk("mid_rst_pops", 64'(rd_ptr - (wr_ptr - 8)), 64'd4);
    reset = 1'b1;
    n0 = tot_cmd; tick(10);
    chk("mid_rst_no_cmd", 64'(tot_cmd - n0), 64'd0);
    push_words(64'h3008, 64'h1, 4);
    wait_cmd(5);
    chk("post_rst_addr", 64'(app_af_addr), 64'h0);
    wait_idle(40);
    chk("post_rst_last", last_wdata, 64'h300B);
    chk("post_rst_count", 64'(burst_count), (STATS_ON != 0) ? 64'd1 : 64'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wr_burst_ctrl.md
# wr_burst_ctrl

Write-path scheduler between the DDR2 write FIFO read port and the MIG user interface. When the FIFO holds at least one burst (prog_empty low), it issues one write command to the address FIFO. It then pops exactly WRITE_BURST words from the FIFO and forwards them to the write-data FIFO, honouring MIG back-pressure. The DDR2 target address advances through a programmable ring region.

## Interface
- DATA_WIDTH, 64: FIFO/MIG write-data width.
- WRITE_BURST, 8: FIFO words per command; power of two, 2..64.
- ADDR_WIDTH, 31: app_af_addr width.
- ADDR_INC, 4: address increment per command.
- rd_clk  in  1  single clock (FIFO read side, MIG user clock); one clock, reset synchronous active-low.
- reset  in  1  synchronous, active-low; sampled on rd_clk rising edge.
- enable  in  1  allow new bursts to start.
- phy_init_done  in  1  MIG calibration complete.
- base_addr  in  ADDR_WIDTH  ring start, sampled at reset release and while busy=0.
- last_addr  in  ADDR_WIDTH  final command address of ring, inclusive.
- prog_empty  in  1  FIFO holds fewer than WRITE_BURST words.
- dout_vd  in  1  FIFO data_out valid.
- data_out  in  DATA_WIDTH  FIFO read data.
- rd_fifo  out  1  FIFO read enable.
- app_af_afull, app_wdf_afull  in  1 each  MIG back-pressure.
- app_af_wren  out  1  command strobe.
- app_af_cmd  out  3  always 3'b000 (write).
- app_af_addr  out  ADDR_WIDTH  command address.
- app_wdf_wren  out  1  write-data strobe.
- app_wdf_data  out  DATA_WIDTH  write data.
- busy  out  1  burst in progress.
- burst_count  out  32  completed bursts (see Configuration).

## Operation
- States: IDLE, CMD, DATA, DONE.
- IDLE -> CMD when enable, phy_init_done, !prog_empty, !app_af_afull and !app_wdf_afull are all high in the same cycle.
- CMD: app_af_wren=1 for exactly one cycle, app_af_addr=cur_addr. Then go to DATA.
- DATA: rd_fifo=1 each cycle while rd_issued<WRITE_BURST and !app_wdf_afull.
  - rd_issued counts pops.
  - wd_sent counts app_wdf_wren pulses.
  - Leave for DONE when wd_sent reaches WRITE_BURST.
- DONE: one cycle.
  - If cur_addr==last_addr then cur_addr<=base_addr, else cur_addr<=cur_addr+ADDR_INC, truncated to ADDR_WIDTH.
  - Then go to IDLE.
- Forwarding: app_wdf_wren and app_wdf_data are registered copies of dout_vd and data_out. A dout_vd outside DATA is ignored.
- enable dropping mid-burst: the current burst completes; no new burst starts.
- dout_vd never arrives: the FSM stays in DATA. No timeout.
- busy=1 in CMD, DATA and DONE.

## Timing
- Reset values: rd_fifo, app_af_wren, app_wdf_wren, busy = 0; app_af_cmd=0; app_af_addr=base_addr; app_wdf_data=0; burst_count=0; state IDLE; counters 0.
- Reset mid-burst: everything returns to reset values on the next edge. A partial burst is abandoned; the FIFO is not drained.
- FIFO read latency: dout_vd follows rd_fifo by 1 cycle. app_wdf_wren follows dout_vd by 1 cycle.
- Unthrottled burst, with start condition true at cycle 0:
  - cycle 1: CMD.
  - cycles 2..WRITE_BURST+1: rd_fifo.
  - last app_wdf_wren at WRITE_BURST+3.
  - DONE at WRITE_BURST+4.
  - IDLE at WRITE_BURST+5.
  - Next CMD no earlier than WRITE_BURST+6.
- app_wdf_afull gates rd_fifo combinationally in the same cycle. At most 2 words are in flight after afull rises; MIG slack absorbs them.
- app_af_afull is checked only in IDLE.

## Configuration
- WR_BURST_CTRL_STATS_EN defined:
  - burst_count increments by 1 in each DONE cycle and wraps at 2^32.
  - It is cleared only by reset.
- Not defined: burst_count is tied to 0 and no counter logic is generated.

## Test plan
- Reset: hold reset=0 for 5 cycles with prog_empty=0 and enable=1 -> all outputs at reset values, no rd_fifo. Release with base_addr=0x100 -> app_af_addr=0x100, and CMD is seen 2 cycles after release.
- Single burst, WRITE_BURST=8: FIFO model returns 0x11..0x88 -> one app_af_wren at addr 0x100; 8 consecutive rd_fifo; app_wdf_data 0x11..0x88 in order; busy low at cycle 13; next address 0x104.
- Back-pressure: app_wdf_afull=1 for cycles 4..7 -> rd_fifo low during those cycles; exactly 8 app_wdf_wren total; data order preserved; no word lost.
- Ring wrap: base=0x0, last=0x8, ADDR_INC=4, 4 bursts -> addresses 0x0, 0x4, 0x8, 0x0.
- Start gating: prog_empty=1 or app_af_afull=1 or phy_init_done=0 -> no CMD. enable dropped during DATA -> burst finishes; no further CMD.
- Stats: with WR_BURST_CTRL_STATS_EN, 3 bursts -> burst_count=3; reset mid-burst -> burst_count=0 and FSM in IDLE. Without the macro, burst_count stays 0.
